gray_counter: RTL and testbench



---
 rtl/gray_counter.sv | 107 ++++++++++
 tb/tb_gray_counter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// rtl/gray_counter.sv - registered Gray-code up/down counter with load, wrap/saturate and boundary flags
// Optional binary mirror output bin_o is enabled by defining GRAY_COUNTER_BIN_OUT_EN.
module gray_counter #(
    parameter int WIDTH = 16,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             dn_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o,
`ifdef GRAY_COUNTER_BIN_OUT_EN
    output logic [WIDTH-1:0] bin_o,
`endif
    output logic             sat_o
);

    localparam logic [WIDTH-1:0] MSB_ONEHOT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] LSB_ONEHOT = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_sat;

    logic             w_parity;
    logic [WIDTH-1:0] w_low;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_hi_flip;
    logic [WIDTH-1:0] w_flip;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;
    logic             w_sat_nxt;

    // Parity decides between flipping bit 0 and the bit left of the lowest set bit;
    // when no such bit exists (max going up, zero going down) the MSB flips, which is the wrap.
    always_comb begin
        w_parity   = ^r_count;
        w_low      = r_count & (~r_count + LSB_ONEHOT);
        w_shift    = w_low << 1;
        w_hi_flip  = (w_shift == '0) ? MSB_ONEHOT : w_shift;
        w_flip     = (w_parity == dn_i) ? LSB_ONEHOT : w_hi_flip;
        w_at_bound = dn_i ? (r_count == '0) : (r_count == MSB_ONEHOT);
    end

    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_sat_nxt   = 1'b0;
        if (load_i) begin
            w_count_nxt = load_val_i;
        end else if (en_i) begin
            if (!w_at_bound) begin
                w_count_nxt = r_count ^ w_flip;
            end else if (WRAP) begin
                w_count_nxt = r_count ^ w_flip;
                w_wrap_nxt  = 1'b1;
            end else begin
                w_sat_nxt   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
            r_sat   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
            r_sat   <= w_sat_nxt;
        end
    end

    assign count_o = r_count;
    assign wrap_o  = r_wrap;
    assign sat_o   = r_sat;

`ifdef GRAY_COUNTER_BIN_OUT_EN
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] r_bin;

    // Registered from the next-state so it never lags count_o.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_bin <= '0;
        end else begin
            r_bin <= gray2bin(w_count_nxt);
        end
    end

    assign bin_o = r_bin;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// tb/tb_gray_counter.sv - table-driven bench for gray_counter at WIDTH=4, wrap and saturate instances
module tb_gray_counter;

    localparam int W = 4;

    typedef struct {
        logic         rst_n;
        logic         en;
        logic         dn;
        logic         ld;
        logic [W-1:0] val;
        logic [W-1:0] exp_cnt;
        logic         exp_wrap;
        logic         exp_sat;
        logic         chk_hd;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         dn = 1'b0;
    logic         ld = 1'b0;
    logic [W-1:0] val = '0;

    logic [W-1:0] cnt_w, cnt_s;
    logic         wrap_w, wrap_s, sat_w, sat_s;
`ifdef GRAY_COUNTER_BIN_OUT_EN
    logic [W-1:0] bin_w, bin_s;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dn_i(dn), .load_i(ld), .load_val_i(val),
        .count_o(cnt_w), .wrap_o(wrap_w),
`ifdef GRAY_COUNTER_BIN_OUT_EN
        .bin_o(bin_w),
`endif
        .sat_o(sat_w)
    );

    gray_counter #(.WIDTH(W), .WRAP(1'b0)) u_sat (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dn_i(dn), .load_i(ld), .load_val_i(val),
        .count_o(cnt_s), .wrap_o(wrap_s),
`ifdef GRAY_COUNTER_BIN_OUT_EN
        .bin_o(bin_s),
`endif
        .sat_o(sat_s)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic d, input logic l, input logic [W-1:0] v);
        rst_n = r; en = e; dn = d; ld = l; val = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic add(input logic r, input logic e, input logic d, input logic l, input logic [W-1:0] v,
                       input logic [W-1:0] c, input logic wr, input logic hd);
        vq.push_back('{r, e, d, l, v, c, wr, 1'b0, hd});
    endtask

    task automatic sat_step(input string name, input logic e, input logic d, input logic l,
                            input logic [W-1:0] v, input logic [W-1:0] c, input logic s);
        drive(1'b1, e, d, l, v);
        chk({name, " cnt"}, 64'(cnt_s), 64'(c));
        chk({name, " sat"}, 64'(sat_s), 64'(s));
        chk({name, " wrap"}, 64'(wrap_s), 64'(0));
    endtask

    logic [W-1:0] prev;
    logic [W-1:0] up_seq [16];

    initial begin
        up_seq = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                   4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

        // reset
        add(0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        // count up and wrap
        for (int i = 0; i < 16; i++) add(1, 1, 0, 0, 4'h0, up_seq[i], (i == 15), 1);
        add(1, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        // count down from zero
        add(0, 1, 1, 0, 4'h0, 4'h0, 0, 0);
        add(1, 1, 1, 0, 4'h0, 4'h8, 1, 1);
        add(1, 1, 1, 0, 4'h0, 4'h9, 0, 1);
        // load priority over enable
        add(1, 1, 0, 1, 4'h5, 4'h5, 0, 0);
        add(1, 0, 1, 0, 4'h0, 4'h5, 0, 0);
        // count to E, then reset while en and load are high
        add(1, 0, 0, 1, 4'hC, 4'hC, 0, 0);
        add(1, 1, 0, 0, 4'h0, 4'hD, 0, 1);
        add(1, 1, 0, 0, 4'h0, 4'hF, 0, 1);
        add(1, 1, 0, 0, 4'h0, 4'hE, 0, 1);
        add(0, 1, 0, 1, 4'h7, 4'h0, 0, 0);
        // direction reversal from 6
        add(1, 0, 0, 1, 4'h6, 4'h6, 0, 0);
        add(1, 1, 0, 0, 4'h0, 4'h7, 0, 1);
        add(1, 1, 1, 0, 4'h0, 4'h6, 0, 1);
        add(1, 1, 0, 0, 4'h0, 4'h7, 0, 1);
        add(1, 1, 1, 0, 4'h0, 4'h6, 0, 1);

        @(negedge clk);
        prev = '0;
        foreach (vq[i]) begin
            drive(vq[i].rst_n, vq[i].en, vq[i].dn, vq[i].ld, vq[i].val);
            chk($sformatf("v%0d cnt", i), 64'(cnt_w), 64'(vq[i].exp_cnt));
            chk($sformatf("v%0d wrap", i), 64'(wrap_w), 64'(vq[i].exp_wrap));
            chk($sformatf("v%0d sat", i), 64'(sat_w), 64'(vq[i].exp_sat));
            if (vq[i].chk_hd)
                chk($sformatf("v%0d hamming", i), 64'($countones(prev ^ cnt_w)), 64'(1));
`ifdef GRAY_COUNTER_BIN_OUT_EN
            chk($sformatf("v%0d bin", i), 64'(bin_w), 64'(ref_bin(vq[i].exp_cnt)));
`endif
            prev = cnt_w;
        end
`ifdef GRAY_COUNTER_BIN_OUT_EN
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'h5);
        chk("load bin", 64'(bin_w), 64'(6));
`endif

        // saturating instance at the top and bottom
        sat_step("sat load8", 0, 0, 1, 4'h8, 4'h8, 0);
        sat_step("sat up1", 1, 0, 0, 4'h0, 4'h8, 1);
        sat_step("sat up2", 1, 0, 0, 4'h0, 4'h8, 1);
        sat_step("sat up3", 1, 0, 0, 4'h0, 4'h8, 1);
        sat_step("sat dn", 1, 1, 0, 4'h0, 4'h9, 0);
        sat_step("sat load0", 1, 0, 1, 4'h0, 4'h0, 0);
        sat_step("sat dn0", 1, 1, 0, 4'h0, 4'h0, 1);
        sat_step("sat idle", 0, 1, 0, 4'h0, 4'h0, 0);
        sat_step("sat up0", 1, 0, 0, 4'h0, 4'h1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
